// File: rtl/display_frame_seq_pkg.sv
// Shared types and helpers for the visual-crypto frame sequencer.
// DISPLAY_FRAME_SEQ_RNDX_EN selects pairwise xor expansion of the random word.
package display_frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_e;

    function automatic int nb_rndx(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Lexicographic position of pair (i,j), i<j, among all pairs of n bits
    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - i * (i + 1) / 2 + (j - i - 1);
    endfunction

`ifdef DISPLAY_FRAME_SEQ_RNDX_EN
    localparam int RNDSIZE_DEF = 5;
`else
    localparam int RNDSIZE_DEF = 7;
`endif

endpackage

// File: rtl/display_frame_seq_if.sv
// Random-word input stream and pixel-row output stream of the sequencer.
// master = sequencer side, slave = TRNG/row-driver side.
interface display_frame_seq_if
    import display_frame_seq_pkg::*;
#(
    parameter int RNDSIZE = RNDSIZE_DEF,
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 8
);
    logic [RNDSIZE-1:0]         rnd;
    logic                       rnd_valid;
    logic                       rnd_ready;
    logic [WIDTH-1:0]           pix_row;
    logic [$clog2(HEIGHT)-1:0]  pix_row_idx;
    logic                       pix_last_row;
    logic                       pix_last_frame;
    logic                       pix_valid;
    logic                       pix_ready;

    modport master (
        input  rnd, rnd_valid, pix_ready,
        output rnd_ready, pix_row, pix_row_idx,
        output pix_last_row, pix_last_frame, pix_valid
    );

    modport slave (
        output rnd, rnd_valid, pix_ready,
        input  rnd_ready, pix_row, pix_row_idx,
        input  pix_last_row, pix_last_frame, pix_valid
    );
endinterface

// File: rtl/display_frame_seq_xorexpand.sv
// Combinational pairwise xor expansion: rndx[k] = rnd[i]^rnd[j], pairs in lexicographic order.
module xorexpand_p
    import display_frame_seq_pkg::*;
#(
    parameter int RNDSIZE = 5,
    parameter int NOUT    = nb_rndx(RNDSIZE)
) (
    input  logic [RNDSIZE-1:0] rnd,
    output logic [NOUT-1:0]    rndx
);
    for (genvar i = 0; i < RNDSIZE; i++) begin : g_i
        for (genvar j = i + 1; j < RNDSIZE; j++) begin : g_j
            localparam int K = pair_index(i, j, RNDSIZE);
            if (K < NOUT) begin : g_out
                assign rndx[K] = rnd[i] ^ rnd[j];
            end
        end
    end
endmodule

// File: rtl/segment2pixel.sv
// Renders a 7-segment glyph onto a WIDTH x HEIGHT bitmap; bit y*WIDTH+x is pixel (x,y).
module segment2pixel #(
    parameter int NB_SEGMENTS = 7,
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 8
) (
    input  logic [NB_SEGMENTS-1:0]  seg,
    output logic [WIDTH*HEIGHT-1:0] pix
);
    // Segment a..g owning pixel (x,y), or -1 for background
    function automatic int seg_owner(input int x, input int y, input int w, input int h);
        int  lw;
        int  mid;
        bit  hb;
        bit  lc;
        bit  rc;
        lw  = (w / 8 > 0) ? w / 8 : 1;
        mid = h / 2;
        hb  = (x >= lw) && (x < w - lw);
        lc  = (x < lw);
        rc  = (x >= w - lw);
        if (y == 0 && hb)                 return 0;
        if (y > 0 && y < mid && rc)       return 1;
        if (y > mid && y < h - 1 && rc)   return 2;
        if (y == h - 1 && hb)             return 3;
        if (y > mid && y < h - 1 && lc)   return 4;
        if (y > 0 && y < mid && lc)       return 5;
        if (y == mid && hb)               return 6;
        return -1;
    endfunction

    for (genvar y = 0; y < HEIGHT; y++) begin : g_y
        for (genvar x = 0; x < WIDTH; x++) begin : g_x
            localparam int OWN = seg_owner(x, y, WIDTH, HEIGHT);
            if (OWN >= 0 && OWN < NB_SEGMENTS) begin : g_on
                assign pix[y*WIDTH+x] = seg[OWN];
            end else begin : g_off
                assign pix[y*WIDTH+x] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/display_frame_seq.sv
// Visual-crypto frame generator: complementary frame pairs streamed row by row.
// Build option DISPLAY_FRAME_SEQ_RNDX_EN enables xor expansion of the random word.
module display_frame_seq
    import display_frame_seq_pkg::*;
#(
    parameter int NB_SEGMENTS = 7,
    parameter int RNDSIZE     = RNDSIZE_DEF,
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 8,
    parameter int NB_FRAMES   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NB_SEGMENTS-1:0] msg,
    output logic                   busy,
    output logic                   done,
    display_frame_seq_if.master    io
);
    localparam int RW = $clog2(HEIGHT);
    localparam int FW = $clog2(NB_FRAMES);

    state_e                 state_q, state_d;
    logic [NB_SEGMENTS-1:0] msg_q, msg_d;
    logic [NB_SEGMENTS-1:0] r_q, r_d;
    logic [NB_SEGMENTS-1:0] selseg_q, selseg_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   done_q, done_d;
    logic [NB_SEGMENTS-1:0] r_new;

`ifdef DISPLAY_FRAME_SEQ_RNDX_EN
    if (nb_rndx(RNDSIZE) < NB_SEGMENTS) begin : g_chk
        $error("RNDSIZE too small for xor expansion");
    end
    xorexpand_p #(
        .RNDSIZE (RNDSIZE),
        .NOUT    (NB_SEGMENTS)
    ) u_xorexpand (
        .rnd  (io.rnd),
        .rndx (r_new)
    );
`else
    if (RNDSIZE < NB_SEGMENTS) begin : g_chk
        $error("RNDSIZE must be >= NB_SEGMENTS without expansion");
    end
    assign r_new = io.rnd[NB_SEGMENTS-1:0];
`endif

    logic [WIDTH*HEIGHT-1:0] pix;
    logic [WIDTH-1:0]        rows [HEIGHT];

    segment2pixel #(
        .NB_SEGMENTS (NB_SEGMENTS),
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT)
    ) u_s2p (
        .seg (selseg_q),
        .pix (pix)
    );

    for (genvar y = 0; y < HEIGHT; y++) begin : g_rows
        assign rows[y] = pix[y*WIDTH +: WIDTH];
    end

    logic beat, last_row, last_frame, can_start;
    assign beat       = (state_q == EMIT) && io.pix_ready && !abort;
    assign last_row   = (row_q == RW'(HEIGHT - 1));
    assign last_frame = (frame_q == FW'(NB_FRAMES - 1));
    assign can_start  = start && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            r_q      <= '0;
            selseg_q <= '0;
            frame_q  <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            r_q      <= r_d;
            selseg_q <= selseg_d;
            frame_q  <= frame_d;
            row_q    <= row_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (can_start) state_d = FETCH;
                FETCH:   if (io.rnd_valid) state_d = EMIT;
                EMIT: begin
                    if (beat && last_row) begin
                        if (last_frame)      state_d = IDLE;
                        else if (frame_q[0]) state_d = FETCH;
                        else                 state_d = EMIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Odd frames reuse the pair's word xored with msg, so no refetch bubble
    always_comb begin
        msg_d    = msg_q;
        r_d      = r_q;
        selseg_d = selseg_q;
        frame_d  = frame_q;
        row_d    = row_q;
        done_d   = 1'b0;
        if (abort) begin
            frame_d = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (can_start) begin
                        msg_d   = msg;
                        frame_d = '0;
                        row_d   = '0;
                    end
                end
                FETCH: begin
                    if (io.rnd_valid) begin
                        r_d      = r_new;
                        selseg_d = r_new;
                    end
                end
                EMIT: begin
                    if (beat && last_row) begin
                        row_d   = '0;
                        frame_d = frame_q + FW'(1);
                        if (last_frame) begin
                            frame_d = '0;
                            done_d  = 1'b1;
                        end else if (!frame_q[0]) begin
                            selseg_d = r_q ^ msg_q;
                        end
                    end else if (beat) begin
                        row_d = row_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy              = (state_q != IDLE);
        done              = done_q;
        io.rnd_ready      = (state_q == FETCH) && !abort;
        io.pix_valid      = (state_q == EMIT) && !abort;
        io.pix_row        = rows[row_q];
        io.pix_row_idx    = row_q;
        io.pix_last_row   = last_row;
        io.pix_last_frame = last_frame;
    end
endmodule

// File: tb/tb_display_frame_seq.sv
// Bench for display_frame_seq.
// Directed steps with a frame/glyph model.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errs++; \
      $error("FAIL %s obs=%0h exp=%0h", \
             tag, (obs), (exp)); \
    end \
  end

module tb_display_frame_seq;
  localparam int NS = 7;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NF = 8;
`ifdef DISPLAY_FRAME_SEQ_RNDX_EN
  localparam int RS = 5;
`else
  localparam int RS = 7;
`endif

  localparam int X0 [7] = '{2, 14, 14, 2, 0, 0, 2};
  localparam int X1 [7] = '{13, 15, 15, 13, 1, 1, 13};
  localparam int Y0 [7] = '{0, 1, 5, 7, 5, 1, 4};
  localparam int Y1 [7] = '{0, 3, 6, 7, 6, 3, 4};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] msg = '0;
  logic          busy;
  logic          done;
  int            checks = 0;
  int            errs = 0;

  display_frame_seq_if #(
    .RNDSIZE (RS),
    .WIDTH   (W),
    .HEIGHT  (H)
  ) io ();

  display_frame_seq #(
    .NB_SEGMENTS (NS),
    .RNDSIZE     (RS),
    .WIDTH       (W),
    .HEIGHT      (H),
    .NB_FRAMES   (NF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .msg   (msg),
    .busy  (busy),
    .done  (done),
    .io    (io)
  );

  always #5 clk = ~clk;

  function automatic logic [NS-1:0] expand(
    input logic [RS-1:0] w
  );
    logic [NS-1:0] r;
    int            k;
    r = '0;
    k = 0;
`ifdef DISPLAY_FRAME_SEQ_RNDX_EN
    for (int i = 0; i < RS; i++)
      for (int j = i + 1; j < RS; j++) begin
        if (k < NS) r[k] = w[i] ^ w[j];
        k++;
      end
`else
    for (int i = 0; i < NS; i++) r[i] = w[i];
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] exp_row(
    input logic [NS-1:0] seg,
    input int y
  );
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < NS; s++)
      if (seg[s] && y >= Y0[s] && y <= Y1[s])
        for (int x = X0[s]; x <= X1[s]; x++)
          r[x] = 1'b1;
    return r;
  endfunction

  task automatic run_msg(
    input  logic [NS-1:0] m,
    input  int            mode,
    input  int            starve_frame,
    input  bit            restart,
    input  bit            fixed,
    input  logic [RS-1:0] frnd,
    output logic [W-1:0]  r00,
    output logic [W-1:0]  r10
  );
    logic [NS-1:0] R, seg;
    logic [W-1:0]  held;
    logic [2:0]    held_idx;
    int            beats, hs, dones, f, y;
    int            cyc, ph, starve;
    bit            stalled, starved, restarted;
    R = '0; r00 = '0; r10 = '0;
    held = '0; held_idx = '0;
    beats = 0; hs = 0; dones = 0;
    f = 0; y = 0; cyc = 0; ph = 0;
    starve = 0; stalled = 0;
    starved = 0; restarted = 0;
    @(negedge clk);
    msg = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    msg = NS'($urandom);
    `CHK("busy_after_start", busy, 1'b1)
    while (f < NF && cyc < 3000) begin
      if (done) dones++;
      if (stalled) begin
        `CHK("stall_valid", io.pix_valid, 1'b1)
        `CHK("stall_row", io.pix_row, held)
        `CHK("stall_idx", io.pix_row_idx, held_idx)
      end
      start = 1'b0;
      if (restart && !restarted && beats == 20) begin
        start = 1'b1;
        msg = ~m;
        restarted = 1;
      end
      case (mode)
        0:       io.pix_ready = 1'b1;
        1:       io.pix_ready = (ph % 4 == 0) ||
                                (ph % 4 == 3);
        default: io.pix_ready = 1'($urandom);
      endcase
      ph++;
      io.rnd = fixed ? frnd : RS'($urandom);
      if (!starved && io.rnd_ready &&
          starve_frame >= 0 &&
          hs == starve_frame / 2) begin
        starve = 20;
        starved = 1;
      end
      if (starve > 0) begin
        io.rnd_valid = 1'b0;
        starve--;
      end else begin
        io.rnd_valid = (mode == 2) ?
                       1'($urandom) : 1'b1;
      end
      #1;
      if (starved && starve > 0) begin
        `CHK("starve_fetch_hold", io.rnd_ready, 1'b1)
        `CHK("starve_no_valid", io.pix_valid, 1'b0)
      end
      if (io.rnd_valid && io.rnd_ready) begin
        R = expand(io.rnd);
        hs++;
      end
      if (io.pix_valid && io.pix_ready) begin
        seg = (f % 2 == 0) ? R : (R ^ m);
        `CHK("row_data", io.pix_row, exp_row(seg, y))
        `CHK("row_idx", io.pix_row_idx, 3'(y))
        `CHK("last_row", io.pix_last_row, (y == H - 1))
        `CHK("last_frame", io.pix_last_frame,
             (f == NF - 1))
        if (f == 0 && y == 0) r00 = io.pix_row;
        if (f == 1 && y == 0) r10 = io.pix_row;
        beats++;
        y++;
        if (y == H) begin
          y = 0;
          f++;
        end
      end
      stalled = io.pix_valid && !io.pix_ready;
      held = io.pix_row;
      held_idx = io.pix_row_idx;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errs++;
      $error("FAIL wait expired after %0d cycles", cyc);
    end
    `CHK("beats", beats, 64)
    `CHK("rnd_handshakes", hs, 4)
    `CHK("no_early_done", dones, 0)
    `CHK("done_pulse", done, 1'b1)
    `CHK("idle_at_done", busy, 1'b0)
    start = 1'b1;
    msg = m;
    @(negedge clk);
    start = 1'b0;
    `CHK("start_on_done_ignored", busy, 1'b0)
    `CHK("done_one_cycle", done, 1'b0)
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           f, y, cyc, dn;
    bit           hit;
    io.rnd = '0;
    io.rnd_valid = 1'b0;
    io.pix_ready = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        io.pix_valid !== 1'b0 ||
        io.rnd_ready !== 1'b0 ||
        io.pix_row !== '0 ||
        io.pix_row_idx !== '0) begin
      errs++;
      $error("FAIL reset state not all zero");
    end
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_pix_valid", io.pix_valid, 1'b0)
    `CHK("rst_rnd_ready", io.rnd_ready, 1'b0)
    `CHK("rst_pix_row", io.pix_row, 16'h0000)
    `CHK("rst_last_frame", io.pix_last_frame, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DISPLAY_FRAME_SEQ_RNDX_EN
    run_msg(7'b0000001, 0, -1, 0, 1, 5'b00011, a, b);
    `CHK("dir_f0_row0", a, 16'h0000)
    `CHK("dir_f1_row0", b, 16'h3FFC)
`else
    run_msg(7'h0F, 0, -1, 0, 1, 7'h55, a, b);
    `CHK("dir_f0_row0", a, 16'h3FFC)
    `CHK("dir_f1_row0", b, 16'h0000)
`endif
    run_msg(NS'($urandom), 1, -1, 0, 0, '0, a, b);
    run_msg(NS'($urandom), 0, 2, 0, 0, '0, a, b);
    run_msg(NS'($urandom), 2, -1, 0, 0, '0, a, b);

    @(negedge clk);
    msg = NS'($urandom);
    start = 1'b1;
    io.pix_ready = 1'b1;
    io.rnd_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f = 0; y = 0; cyc = 0; hit = 0;
    while (!hit && cyc < 500) begin
      io.rnd = RS'($urandom);
      if (io.pix_valid && f == 3 && y == 4) begin
        `CHK("abort_at_row", io.pix_row_idx, 3'd4)
        abort = 1'b1;
        hit = 1;
        #1;
        `CHK("abort_drop_valid", io.pix_valid, 1'b0)
        `CHK("abort_drop_ready", io.rnd_ready, 1'b0)
      end else begin
        #1;
        if (io.pix_valid && io.pix_ready) begin
          y++;
          if (y == H) begin
            y = 0;
            f++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    `CHK("abort_reached", hit, 1'b1)
    `CHK("abort_busy", busy, 1'b0)
    `CHK("abort_valid", io.pix_valid, 1'b0)
    dn = 0;
    if (done) dn++;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    `CHK("abort_no_done", dn, 0)
    run_msg(NS'($urandom), 0, -1, 0, 0, '0, a, b);

    @(negedge clk);
    msg = NS'($urandom);
    start = 1'b1;
    io.pix_ready = 1'b1;
    io.rnd_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!io.pix_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    `CHK("rst_reach_emit", io.pix_valid, 1'b1)
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("arst_busy", busy, 1'b0)
    `CHK("arst_valid", io.pix_valid, 1'b0)
    `CHK("arst_rnd_ready", io.rnd_ready, 1'b0)
    `CHK("arst_row", io.pix_row, 16'h0000)
    `CHK("arst_idx", io.pix_row_idx, 3'd0)
    `CHK("arst_done", done, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;
    run_msg(NS'($urandom), 2, -1, 1, 0, '0, a, b);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
